// File: rtl/max7219_serializer.sv
// max7219_serializer: sends MAX7219 init frames after reset, then one
// four-digit BCD update frame set per accepted start, over a 3-wire bus.
module max7219_serializer #(
  parameter int         CLK_DIV   = 2,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_start,
  input  logic [3:0] i_hours_tens,
  input  logic [3:0] i_hours_ones,
  input  logic [3:0] i_min_tens,
  input  logic [3:0] i_min_ones,
  input  logic       i_colon,
  output logic       o_busy,
  output logic       o_serial_dout,
  output logic       o_serial_load,
  output logic       o_serial_clk
);

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_IDLE  = 3'd2;
  localparam logic [2:0] ST_ARM   = 3'd3;
  localparam logic [2:0] ST_UPD   = 3'd4;

  localparam logic [1:0] PH_SHIFT = 2'd0;
  localparam logic [1:0] PH_LOAD  = 2'd1;
  localparam logic [1:0] PH_GAP   = 2'd2;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  frame_q, frame_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] dig_q, dig_d;
  logic        colon_q, colon_d;
  logic        busy_q, busy_d;
  logic        dout_q, dout_d;
  logic        load_q, load_d;
  logic        sclk_q, sclk_d;

  logic        in_init;
  logic        div_last;
  logic [2:0]  last_frame;
  logic [15:0] cur_word;

  function automatic logic [15:0] frame_word(
    input logic        init,
    input logic [2:0]  idx,
    input logic [15:0] dig,
    input logic        colon
  );
    logic [3:0] d;
    logic [7:0] data;
    d = 4'h0;
    data = 8'h00;
    frame_word = 16'h0000;
    if (init) begin
      unique case (idx)
        3'd0:    frame_word = 16'h0C00;
        3'd1:    frame_word = 16'h0F00;
        3'd2:    frame_word = 16'h090F;
        3'd3:    frame_word = {12'h0A0, INTENSITY};
        3'd4:    frame_word = 16'h0B03;
        default: frame_word = 16'h0C01;
      endcase
    end else begin
      // a zero hours-tens digit is blanked with code-B 0xF
      unique case (idx[1:0])
        2'd0:    d = (dig[15:12] == 4'h0) ? 4'hF : dig[15:12];
        2'd1:    d = dig[11:8];
        2'd2:    d = dig[7:4];
        default: d = dig[3:0];
      endcase
      data = {colon & (idx == 3'd1), 3'b000, d};
      frame_word = {4'h0, {1'b0, idx} + 4'd1, data};
    end
  endfunction

  assign in_init    = (state_q == ST_INIT);
  assign div_last   = (div_q == DIV_LAST);
  assign last_frame = in_init ? 3'd5 : 3'd3;
  assign cur_word   = frame_word(in_init, frame_q, dig_q, colon_q);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    div_d   = div_q;
    dig_d   = dig_q;
    colon_d = colon_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    load_d  = load_q;
    sclk_d  = sclk_q;
    unique case (state_q)
      ST_RESET, ST_ARM: begin
        // every frame begins with a zero nibble, so bit 15 is always 0
        state_d = (state_q == ST_RESET) ? ST_INIT : ST_UPD;
        phase_d = PH_SHIFT;
        frame_d = 3'd0;
        bit_d   = 4'd15;
        div_d   = 8'd0;
        busy_d  = 1'b1;
        dout_d  = 1'b0;
        load_d  = 1'b0;
        sclk_d  = 1'b0;
      end
      ST_IDLE: begin
        if (i_en && i_start) begin
          state_d = ST_ARM;
          dig_d   = {i_hours_tens, i_hours_ones, i_min_tens, i_min_ones};
          colon_d = i_colon;
        end
      end
      ST_INIT, ST_UPD: begin
        div_d = div_last ? 8'd0 : div_q + 8'd1;
        if (div_last) begin
          unique case (phase_q)
            PH_SHIFT: begin
              if (!sclk_q) begin
                sclk_d = 1'b1;
              end else begin
                sclk_d = 1'b0;
                if (bit_q == 4'd0) begin
                  phase_d = PH_LOAD;
                  dout_d  = 1'b0;
                  load_d  = 1'b1;
                end else begin
                  bit_d  = bit_q - 4'd1;
                  dout_d = cur_word[bit_q - 4'd1];
                end
              end
            end
            PH_LOAD: begin
              phase_d = PH_GAP;
              load_d  = 1'b0;
            end
            PH_GAP: begin
              if (frame_q == last_frame) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end else begin
                frame_d = frame_q + 3'd1;
                phase_d = PH_SHIFT;
                bit_d   = 4'd15;
                dout_d  = 1'b0;
              end
            end
            default: phase_d = PH_SHIFT;
          endcase
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_RESET;
      phase_q <= PH_SHIFT;
      frame_q <= 3'd0;
      bit_q   <= 4'd0;
      div_q   <= 8'd0;
      dig_q   <= 16'h0000;
      colon_q <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= 1'b0;
      load_q  <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      dig_q   <= dig_d;
      colon_q <= colon_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      load_q  <= load_d;
      sclk_q  <= sclk_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_serial_dout = dout_q;
  assign o_serial_load = load_q;
  assign o_serial_clk  = sclk_q;

endmodule
